// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int          FQ_XLEN = 64;
    localparam int          FQ_ILEN = 32;
    localparam logic [31:0] FQ_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Circular FIFO with synchronous clear; pop on empty is ignored, caller never pushes when full.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (occ != '0);
    assign do_push = push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occ gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail] <= wdata;
    end

    assign rdata = mem[head];
    assign count = occ;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue: owns the fetch PC, keeps one imem request in flight, buffers {pc, instr}.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | no request outstanding
//   ST_WAIT | request outstanding, its response is pushed
//   ST_DROP | request outstanding, its response is discarded
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = FQ_XLEN,
    parameter int              ILEN     = FQ_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [ILEN-1:0] NOP      = FQ_NOP
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_valid,
    input  logic [ILEN-1:0]        imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   deq,
    output logic                   out_valid,
    output logic [ILEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state;
    logic [XLEN-1:0]       fetch_pc;
    logic [XLEN-1:0]       req_pc;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         count_after_pop;
    logic [XLEN+ILEN-1:0]  head;
    logic                  has_head;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign has_head        = (fifo_count != '0);
    assign pop             = deq && has_head && !redirect;
    assign push            = (state == ST_WAIT) && imem_valid && !redirect;
    assign count_after_pop = fifo_count - {{(CW-1){1'b0}}, pop};
    // Issue only from IDLE, so nothing is in flight and the new request reserves the free slot.
    assign issue           = !reset && (state == ST_IDLE) && !redirect &&
                             (count_after_pop < CW'(DEPTH));

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc, imem_rdata}),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            // A response arriving with the redirect retires the outstanding request.
            if (state != ST_IDLE) state <= imem_valid ? ST_IDLE : ST_DROP;
        end else begin
            case (state)
                ST_IDLE: if (issue) begin
                    state    <= ST_WAIT;
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                ST_WAIT: if (imem_valid) state <= ST_IDLE;
                ST_DROP: if (imem_valid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign out_valid = has_head;
    assign out_instr = has_head ? head[ILEN-1:0] : NOP;
    assign out_pc    = has_head ? head[XLEN+ILEN-1:ILEN] : '0;
    assign count     = fifo_count;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset)
            assert (!(state == ST_IDLE && imem_valid))
            else $warning("imem_valid ignored: no request outstanding");
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a single-outstanding memory responder.
module tb_fetch_queue;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    bit          mem_pending;
    logic [63:0] mem_addr;
    int          mem_wait;
    int          lat;
    bit          lat_rand;
    int          req_cnt;
    bit          req_seen;
    logic [63:0] last_req_addr;
    logic [63:0] exp_pc;
    int          pops;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'h00a0_0093 + a[31:0];
    endfunction

    // Called at a negedge: drive memory, observe request and pops, advance one clock.
    task automatic cycle();
        imem_valid = 1'b0;
        if (mem_pending) begin
            if (mem_wait == 0) begin
                imem_valid  = 1'b1;
                imem_rdata  = instr_of(mem_addr);
                mem_pending = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        #1;
        if (deq && out_valid && !redirect) begin
            chk("pop_pc", out_pc, exp_pc);
            chk("pop_instr", out_instr, instr_of(exp_pc));
            exp_pc += 64'd4;
            pops++;
        end
        req_seen = imem_req;
        if (imem_req) begin
            req_cnt++;
            last_req_addr = imem_addr;
            mem_pending   = 1'b1;
            mem_addr      = imem_addr;
            mem_wait      = lat_rand ? int'($urandom_range(0, 4)) : lat - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        mem_pending = 1'b0;
        imem_valid  = 1'b0;
        deq         = 1'b0;
        redirect    = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        exp_pc  = 64'h0;
        req_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        mem_pending = 1'b0; mem_addr = '0; mem_wait = 0; lat = 1; lat_rand = 1'b0;
        req_cnt = 0; req_seen = 1'b0; last_req_addr = '0; exp_pc = '0; pops = 0;

        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr, NOP_I);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_count", count, 3'd0);
        chk("rst_imem_req", imem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Fill with 1-cycle memory, no consumer
        cycle();
        chk("fill_first_req", req_seen, 1'b1);
        chk("fill_first_addr", last_req_addr, 64'h0);
        repeat (7) cycle();
        chk("fill_count", count, 3'd4);
        chk("fill_head_pc", out_pc, 64'h0);
        chk("fill_head_instr", out_instr, 32'h00a0_0093);
        repeat (4) cycle();
        chk("fill_req_cnt", req_cnt, 4);
        chk("fill_no_req", imem_req, 1'b0);

        // One dequeue from full frees exactly one slot
        deq = 1'b1;
        cycle();
        deq = 1'b0;
        chk("deq_req", req_seen, 1'b1);
        chk("deq_req_addr", last_req_addr, 64'd16);
        chk("deq_count_dip", count, 3'd3);
        cycle();
        chk("deq_count_refill", count, 3'd4);
        repeat (3) cycle();
        chk("deq_req_cnt", req_cnt, 5);
        chk("deq_head_pc", out_pc, 64'd4);

        // Redirect while the request for addr 8 is outstanding
        apply_reset();
        repeat (4) cycle();
        lat = 4;
        cycle();
        chk("redir_wait_addr", last_req_addr, 64'd8);
        redirect = 1'b1; redirect_pc = 64'h40;
        cycle();
        redirect = 1'b0;
        chk("redir_no_req", req_seen, 1'b0);
        chk("redir_count", count, 3'd0);
        chk("redir_out_valid", out_valid, 1'b0);
        chk("redir_out_instr", out_instr, NOP_I);
        chk("redir_out_pc", out_pc, 64'h0);
        exp_pc = 64'h40;
        lat = 1;
        repeat (3) cycle();
        chk("redir_late_drop", count, 3'd0);
        cycle();
        chk("redir_req", req_seen, 1'b1);
        chk("redir_req_addr", last_req_addr, 64'h40);
        cycle();
        chk("redir_head_valid", out_valid, 1'b1);
        chk("redir_head_pc", out_pc, 64'h40);
        chk("redir_head_instr", out_instr, instr_of(64'h40));

        // Redirect, response and dequeue on the same edge
        cycle();
        chk("same_wait_addr", last_req_addr, 64'h44);
        redirect = 1'b1; redirect_pc = 64'h100; deq = 1'b1;
        cycle();
        redirect = 1'b0; deq = 1'b0;
        chk("same_no_req", req_seen, 1'b0);
        chk("same_count", count, 3'd0);
        chk("same_out_valid", out_valid, 1'b0);
        exp_pc = 64'h100;
        cycle();
        chk("same_req", req_seen, 1'b1);
        chk("same_req_addr", last_req_addr, 64'h100);
        cycle();
        chk("same_head_pc", out_pc, 64'h100);
        chk("same_count_1", count, 3'd1);

        // Async reset in WAIT with 3 entries; stale response after release
        repeat (5) cycle();
        chk("ar_pre_count", count, 3'd3);
        chk("ar_pre_pending", mem_pending, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_count", count, 3'd0);
        chk("ar_out_instr", out_instr, NOP_I);
        chk("ar_out_pc", out_pc, 64'h0);
        chk("ar_imem_req", imem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0; exp_pc = 64'h0; req_cnt = 0;
        cycle();
        chk("ar_restart_req", req_seen, 1'b1);
        chk("ar_restart_addr", last_req_addr, 64'h0);
        chk("ar_stale_dropped", count, 3'd0);
        cycle();
        chk("ar_head_pc", out_pc, 64'h0);
        chk("ar_head_instr", out_instr, instr_of(64'h0));

        // Random latency 1..5, continuous consumer, 1000 instructions
        lat_rand = 1'b1; deq = 1'b1; pops = 0;
        for (int i = 0; i < 8000 && pops < 1000; i++) cycle();
        chk("stream_pops", pops, 1000);

        // PC wrap from all-ones minus 3 to zero
        lat_rand = 1'b0; lat = 1; deq = 1'b0;
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect = 1'b0;
        exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        deq = 1'b1; pops = 0;
        for (int i = 0; i < 100 && pops < 4; i++) cycle();
        chk("wrap_pops", pops, 4);
        chk("wrap_exp_pc", exp_pc, 64'hC);
        deq = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
